// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle for one pipeline stage register.
// Signal names are from the stage's point of view; master drives the stage, slave is the stage.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96
) ();
  logic              i_valid;
  logic [CTRL_W-1:0] i_ctrl;
  logic [DATA_W-1:0] i_data;
  logic              i_ready;
  logic              o_ready;
  logic              o_valid;
  logic [CTRL_W-1:0] o_ctrl;
  logic [DATA_W-1:0] o_data;

  modport master (
    output i_valid, i_ctrl, i_data, i_ready,
    input  o_ready, o_valid, o_ctrl, o_data
  );
  modport slave (
    input  i_valid, i_ctrl, i_data, i_ready,
    output o_ready, o_valid, o_ctrl, o_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: stall-vector latch (MODE 0) or elastic
// valid/ready stage with a 2-entry skid buffer (MODE 1), plus stall-cycle counter.
module pipe_stage_reg #(
  parameter int CTRL_W     = 8,
  parameter int DATA_W     = 96,
  parameter int STALL_W    = 6,
  parameter int STAGE      = 3,
  parameter int CLEAR_DATA = 1,
  parameter int MODE       = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  pipe_stage_reg_if.slave    bus,
  output logic               o_bubble,
  output logic [15:0]        o_stall_cnt
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_valid, w_valid_nxt;
  logic [CTRL_W-1:0] r_ctrl, w_ctrl_nxt, r_sk_ctrl, w_sk_ctrl_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt, r_sk_data, w_sk_data_nxt;
  logic              r_ready, r_bubble;
  logic [15:0]       r_cnt;
  logic              w_kill, w_stalled, w_accept, w_drain;

  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = r_valid;
    w_ctrl_nxt    = r_ctrl;
    w_data_nxt    = r_data;
    w_sk_ctrl_nxt = r_sk_ctrl;
    w_sk_data_nxt = r_sk_data;
    w_kill        = 1'b0;
    w_stalled     = 1'b0;
    w_accept      = 1'b0;
    w_drain       = 1'b0;
    if (MODE == 0) begin
      // Upstream frozen while downstream runs: emit a bubble rather than duplicate.
      if (flush || (stall[STAGE] && !stall[STAGE+1])) begin
        w_kill = 1'b1;
      end else if (!stall[STAGE]) begin
        w_valid_nxt = bus.i_valid;
        w_ctrl_nxt  = bus.i_ctrl;
        w_data_nxt  = bus.i_data;
      end else begin
        w_stalled = r_valid;
      end
    end else begin
      w_accept  = bus.i_valid & r_ready;
      w_drain   = r_valid & bus.i_ready;
      w_stalled = r_valid & ~bus.i_ready;
      if (flush) begin
        w_kill = 1'b1;
      end else begin
        unique case (r_state)
          S_EMPTY: if (w_accept) begin
            w_state_nxt = S_ONE;
            w_ctrl_nxt  = bus.i_ctrl;
            w_data_nxt  = bus.i_data;
          end
          S_ONE: begin
            if (w_accept && w_drain) begin
              w_ctrl_nxt = bus.i_ctrl;
              w_data_nxt = bus.i_data;
            end else if (w_accept) begin
              w_state_nxt   = S_TWO;
              w_sk_ctrl_nxt = bus.i_ctrl;
              w_sk_data_nxt = bus.i_data;
            end else if (w_drain) begin
              w_state_nxt = S_EMPTY;
            end
          end
          S_TWO: if (w_drain) begin
            w_state_nxt = S_ONE;
            w_ctrl_nxt  = r_sk_ctrl;
            w_data_nxt  = r_sk_data;
          end
          default: w_state_nxt = S_EMPTY;
        endcase
      end
      w_valid_nxt = (w_state_nxt != S_EMPTY);
    end
    if (w_kill) begin
      w_state_nxt = S_EMPTY;
      w_valid_nxt = 1'b0;
      w_ctrl_nxt  = '0;
      w_data_nxt  = (CLEAR_DATA != 0) ? '0 : r_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_EMPTY;
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_data    <= '0;
      r_sk_ctrl <= '0;
      r_sk_data <= '0;
      r_ready   <= 1'b1;
      r_bubble  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_data    <= w_data_nxt;
      r_sk_ctrl <= w_sk_ctrl_nxt;
      r_sk_data <= w_sk_data_nxt;
      r_ready   <= (w_state_nxt != S_TWO);
      r_bubble  <= w_kill;
      if (w_stalled && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
  end

  // MODE 1 ready is registered so it never depends combinationally on i_ready.
  assign bus.o_ready  = (MODE == 0) ? ~stall[STAGE] : r_ready;
  assign bus.o_valid  = r_valid;
  assign bus.o_ctrl   = r_ctrl;
  assign bus.o_data   = r_data;
  assign o_bubble     = r_bubble;
  assign o_stall_cnt  = r_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one MODE 0 and one MODE 1 instance, scoreboard on the elastic stage.
module tb_pipe_stage_reg;
  localparam int CW = 8, DW = 96, SW = 6;

  logic clk = 1'b0, reset;
  logic [SW-1:0] stall;
  logic flush0, flush1, bub0, bub1;
  logic [15:0] cnt0, cnt1;
  int errors = 0, checks = 0, npush = 0, npop = 0;
  logic [DW-1:0] q1[$];
  logic [CW+DW:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus0 ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus1 ();

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STALL_W(SW), .STAGE(3), .CLEAR_DATA(1), .MODE(0)) u_m0 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush0), .bus(bus0),
    .o_bubble(bub0), .o_stall_cnt(cnt0));
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STALL_W(SW), .STAGE(3), .CLEAR_DATA(1), .MODE(1)) u_m1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush1), .bus(bus1),
    .o_bubble(bub1), .o_stall_cnt(cnt1));

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Elastic-stage scoreboard: handshakes are evaluated mid-cycle, before the next edge.
  always @(negedge clk) begin
    if (reset || flush1) q1.delete();
    else begin
      if (bus1.o_valid && bus1.i_ready) begin
        if (q1.size() == 0) chk("m1_unexp", 1, 0);
        else begin chk("m1_sb", bus1.o_data, q1.pop_front()); npop++; end
      end
      if (bus1.i_valid && bus1.o_ready) begin q1.push_back(bus1.i_data); npush++; end
    end
  end

  initial begin
    logic [CW+DW:0] e;
    logic [DW-1:0] d;
    reset = 1; stall = '0; flush0 = 0; flush1 = 0;
    bus0.i_valid = 0; bus0.i_ctrl = '0; bus0.i_data = '0; bus0.i_ready = 0;
    bus1.i_valid = 0; bus1.i_ctrl = '0; bus1.i_data = '0; bus1.i_ready = 0;
    tick(); tick();
    reset = 0;
    chk("rst_valid", bus0.o_valid, 0);
    chk("rst_ctrl", bus0.o_ctrl, 0);
    chk("rst_data", bus0.o_data, 0);
    chk("rst_bub", bub0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_m1_rdy", bus1.o_ready, 1);
    chk("rst_m1_valid", bus1.o_valid, 0);

    // MODE 0 load / bubble / hold / flush
    bus0.i_valid = 1; bus0.i_ctrl = 8'hA5; bus0.i_data = 96'h1234; tick();
    chk("m0_ld_valid", bus0.o_valid, 1);
    chk("m0_ld_ctrl", bus0.o_ctrl, 8'hA5);
    chk("m0_ld_data", bus0.o_data, 96'h1234);
    chk("m0_rdy", bus0.o_ready, 1);
    stall = 6'b001000; bus0.i_ctrl = 8'h5A; #1;
    chk("m0_rdy_stall", bus0.o_ready, 0);
    tick();
    chk("m0_bub_valid", bus0.o_valid, 0);
    chk("m0_bub_ctrl", bus0.o_ctrl, 0);
    chk("m0_bub_data", bus0.o_data, 0);
    chk("m0_bub_pulse", bub0, 1);
    stall = 6'b010000; bus0.i_ctrl = 8'h3C; bus0.i_data = 96'hABCD; tick();
    chk("m0_dn_ld_ctrl", bus0.o_ctrl, 8'h3C);
    chk("m0_bub_clr", bub0, 0);
    stall = 6'b011000; bus0.i_ctrl = 8'hFF; bus0.i_data = 96'h9999;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("m0_hold_ctrl", bus0.o_ctrl, 8'h3C);
      chk("m0_hold_data", bus0.o_data, 96'hABCD);
      chk("m0_hold_cnt", cnt0, 16'(k));
    end
    flush0 = 1; tick();
    chk("m0_fl_valid", bus0.o_valid, 0);
    chk("m0_fl_ctrl", bus0.o_ctrl, 0);
    chk("m0_fl_bub", bub0, 1);
    chk("m0_fl_cnt", cnt0, 3);
    flush0 = 0; stall = '0;
    for (int i = 0; i < 10; i++) begin
      bus0.i_valid = 1'($urandom_range(1)); bus0.i_ctrl = 8'($urandom);
      bus0.i_data = {$urandom, $urandom, $urandom};
      q0.push_back({bus0.i_valid, bus0.i_ctrl, bus0.i_data});
      tick();
      e = q0.pop_front();
      chk("m0_str_valid", bus0.o_valid, e[CW+DW]);
      chk("m0_str_ctrl", bus0.o_ctrl, e[CW+DW-1:DW]);
      chk("m0_str_data", bus0.o_data, e[DW-1:0]);
    end
    // counter saturation
    bus0.i_valid = 1; tick();
    stall = 6'b011000;
    repeat (65540) @(posedge clk);
    #1;
    chk("m0_sat", cnt0, 16'hFFFF);
    tick();
    chk("m0_sat_stay", cnt0, 16'hFFFF);
    chk("m0_sat_valid", bus0.o_valid, 1);
    stall = '0;

    // MODE 1 skid: three pushes against a blocked consumer
    bus1.i_ready = 0; bus1.i_valid = 1; bus1.i_data = 96'd1; tick();
    chk("m1_rdy_one", bus1.o_ready, 1);
    bus1.i_data = 96'd2; tick();
    chk("m1_rdy_two", bus1.o_ready, 0);
    chk("m1_valid", bus1.o_valid, 1);
    bus1.i_data = 96'd3; tick();
    chk("m1_cnt", cnt1, 2);
    bus1.i_ready = 1;
    chk("m1_out1", bus1.o_data, 96'd1);
    tick();
    chk("m1_out2", bus1.o_data, 96'd2);
    chk("m1_rdy_back", bus1.o_ready, 1);
    tick();
    bus1.i_valid = 0;
    chk("m1_out3", bus1.o_data, 96'd3);
    tick();
    chk("m1_empty", bus1.o_valid, 0);
    chk("m1_cnt_fin", cnt1, 2);

    // full-rate stream
    for (int i = 0; i < 20; i++) begin
      d = {$urandom, $urandom, $urandom};
      bus1.i_valid = 1; bus1.i_data = d; tick();
      chk("m1_tp_rdy", bus1.o_ready, 1);
      chk("m1_tp_lat", bus1.o_data, d);
    end
    bus1.i_valid = 0; tick(); tick();
    chk("m1_tp_cnt", 32'(npop), 32'(npush));
    chk("m1_tp_q", 32'(q1.size()), 0);

    // flush overrides accept
    bus1.i_ready = 0; bus1.i_valid = 1; bus1.i_data = 96'd77; tick();
    chk("m1_fl_pre", bus1.o_valid, 1);
    flush1 = 1; bus1.i_data = 96'd88; tick();
    chk("m1_fl_valid", bus1.o_valid, 0);
    chk("m1_fl_bub", bub1, 1);
    chk("m1_fl_rdy", bus1.o_ready, 1);
    flush1 = 0; bus1.i_valid = 0; tick();
    chk("m1_fl_bub0", bub1, 0);
    chk("m1_fl_empty", bus1.o_valid, 0);

    // reset while holding two entries
    bus1.i_valid = 1; bus1.i_data = 96'd5; tick();
    bus1.i_data = 96'd6; tick();
    bus1.i_valid = 0; tick();
    chk("m1_two_rdy", bus1.o_ready, 0);
    reset = 1; tick(); reset = 0;
    chk("m1_rst_valid", bus1.o_valid, 0);
    chk("m1_rst_rdy", bus1.o_ready, 1);
    chk("m1_rst_cnt", cnt1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
